// File: rtl/fw_config_shift_ctrl.sv
// Configuration shift-chain sequencer: fetches chain bits from a word buffer,
// drives config_clk/config_in LSB-first at a programmable rate, pulses
// config_load after the last bit, and writes every returned config_out bit
// into a readback buffer. Pin outputs are registered and aligned to the FSM
// state, so each state's duration is exactly what appears on the pins.
module fw_config_shift_ctrl #(
  parameter int MAX_BITS = 1024,
  parameter int AW       = 5,
  parameter int NB_W     = 11
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  input  logic            start,
  input  logic            abort,
  input  logic [NB_W-1:0] num_bits,
  input  logic [7:0]      half_period,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_rd_addr,
  input  logic [31:0]     mem_rd_data,
  output logic            rb_wr_en,
  output logic [AW-1:0]   rb_wr_addr,
  output logic [31:0]     rb_wr_data,
  output logic            config_clk,
  output logic            config_in,
  output logic            config_load,
  input  logic            config_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOW, S_HIGH, S_LOAD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NB_W-1:0]   n_q, n_d;
  logic [7:0]        h_q, h_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NB_W-1:0]   b_q, b_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rb_word_q, rb_word_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]     mem_rd_addr_q, mem_rd_addr_d;
  logic              rb_wr_en_q, rb_wr_en_d;
  logic [AW-1:0]     rb_wr_addr_q, rb_wr_addr_d;
  logic [31:0]       rb_wr_data_q, rb_wr_data_d;
  logic              cfg_clk_q, cfg_clk_d;
  logic              cfg_in_q, cfg_in_d;
  logic              cfg_load_q, cfg_load_d;

  logic [31:0]       rb_new;
  logic [NB_W-1:0]   b_inc;
  logic              last_bit;
  logic              word_end;

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign rb_wr_en    = rb_wr_en_q;
  assign rb_wr_addr  = rb_wr_addr_q;
  assign rb_wr_data  = rb_wr_data_q;
  assign config_clk  = cfg_clk_q;
  assign config_in   = cfg_in_q;
  assign config_load = cfg_load_q;

  // Next-state and next-output logic; pin registers are decoded from the
  // next state so they line up with the state register cycle for cycle.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    h_d          = h_q;
    cnt_d        = cnt_q;
    b_d          = b_q;
    word_d       = word_q;
    rb_word_d    = rb_word_q;
    aborted_d    = 1'b0;
    rb_wr_en_d   = 1'b0;
    rb_wr_addr_d = rb_wr_addr_q;
    rb_wr_data_d = rb_wr_data_q;
    cfg_in_d     = cfg_in_q;

    rb_new             = rb_word_q;
    rb_new[b_q[4:0]]   = config_out;
    b_inc              = b_q + NB_W'(1);
    last_bit           = (b_q == n_q - NB_W'(1));
    word_end           = (b_q[4:0] == 5'd31);

    case (state_q)
      S_IDLE: begin
        cfg_in_d = 1'b0;
        if (start && !abort) begin
          if (num_bits == '0) begin
            state_d = S_DONE;
          end else begin
            n_d       = (num_bits > NB_W'(MAX_BITS)) ? NB_W'(MAX_BITS) : num_bits;
            h_d       = (half_period == 8'd0) ? 8'd1 : half_period;
            b_d       = '0;
            rb_word_d = '0;
            state_d   = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        word_d   = mem_rd_data;
        cfg_in_d = mem_rd_data[b_q[4:0]];
        cnt_d    = h_q - 8'd1;
        state_d  = S_LOW;
      end
      S_LOW: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = h_q - 8'd1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == 8'd0) begin
          // Completed words (or the partial last word) go to readback;
          // the assembly word is cleared so unused upper bits read as 0.
          if (word_end || last_bit) begin
            rb_wr_en_d   = 1'b1;
            rb_wr_addr_d = AW'(b_q >> 5);
            rb_wr_data_d = rb_new;
            rb_word_d    = '0;
          end else begin
            rb_word_d = rb_new;
          end
          b_d = b_inc;
          if (last_bit) begin
            cnt_d    = h_q - 8'd1;
            cfg_in_d = 1'b0;
            state_d  = S_LOAD;
          end else if (word_end) begin
            state_d = S_FETCH;
          end else begin
            cnt_d    = h_q - 8'd1;
            cfg_in_d = word_q[b_inc[4:0]];
            state_d  = S_LOW;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOAD: begin
        cfg_in_d = 1'b0;
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        cfg_in_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition, including a pending readback write.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      aborted_d  = 1'b1;
      rb_wr_en_d = 1'b0;
      cfg_in_d   = 1'b0;
    end

    done_d        = (state_d == S_DONE);
    mem_rd_en_d   = (state_d == S_FETCH);
    mem_rd_addr_d = (state_d == S_FETCH) ? AW'(b_d >> 5) : '0;
    cfg_clk_d     = (state_d == S_HIGH);
    cfg_load_d    = (state_d == S_LOAD);
  end

  // State, latched fields and registered outputs with async active-low reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      h_q           <= '0;
      cnt_q         <= '0;
      b_q           <= '0;
      word_q        <= '0;
      rb_word_q     <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      rb_wr_en_q    <= 1'b0;
      rb_wr_addr_q  <= '0;
      rb_wr_data_q  <= '0;
      cfg_clk_q     <= 1'b0;
      cfg_in_q      <= 1'b0;
      cfg_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      h_q           <= h_d;
      cnt_q         <= cnt_d;
      b_q           <= b_d;
      word_q        <= word_d;
      rb_word_q     <= rb_word_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rb_wr_en_q    <= rb_wr_en_d;
      rb_wr_addr_q  <= rb_wr_addr_d;
      rb_wr_data_q  <= rb_wr_data_d;
      cfg_clk_q     <= cfg_clk_d;
      cfg_in_q      <= cfg_in_d;
      cfg_load_q    <= cfg_load_d;
    end
  end

endmodule
